// File: rtl/inst_decode_pipe_if.sv
// Instruction-in / decoded-out bundle between PE instruction memory, decode stage and datapath control.
// master drives instructions and consumes decoded outputs; slave is the decode stage.
interface inst_decode_pipe_if #(
  parameter int unsigned FN_LEN           = 3,
  parameter int unsigned NAME_LEN         = 3,
  parameter int unsigned INDEX_LEN        = 8,
  parameter int unsigned WEIGHT_ADDR_LEN  = 5,
  parameter int unsigned INTERIM_ADDR_LEN = 2,
  parameter int unsigned PE_BUS_INDEX_LEN = 4,
  parameter int unsigned GB_BUS_INDEX_LEN = 4,
  parameter int unsigned CNT_LEN          = 16
);
  localparam int unsigned INST_LEN = FN_LEN + 2*(NAME_LEN + INDEX_LEN) + 1 + INTERIM_ADDR_LEN + 1
                                   + WEIGHT_ADDR_LEN + 2 + PE_BUS_INDEX_LEN + GB_BUS_INDEX_LEN;

  logic [INST_LEN-1:0]           inst_word;
  logic                          inst_valid;
  logic                          inst_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [FN_LEN-1:0]             fn;
  logic [NAME_LEN-1:0]           src0_name;
  logic [INDEX_LEN-1:0]          src0_index;
  logic [NAME_LEN-1:0]           src1_name;
  logic [INDEX_LEN-1:0]          src1_index;
  logic                          dest_interim_wrt;
  logic [INTERIM_ADDR_LEN-1:0]   dest_interim_index;
  logic                          dest_weight_wrt;
  logic [WEIGHT_ADDR_LEN-1:0]    dest_weight_index;
  logic                          dest_pu_neigh_wrt;
  logic                          dest_pe_neigh_wrt;
  logic                          dest_pe_bus_wrt;
  logic [PE_BUS_INDEX_LEN-2:0]   dest_pe_bus_index;
  logic                          dest_gb_bus_wrt;
  logic [GB_BUS_INDEX_LEN-2:0]   dest_gb_bus_index;
  logic [INDEX_LEN-1:0]          repeat_left;
  logic [CNT_LEN-1:0]            issue_count;

  modport master (
    output inst_word, inst_valid, out_ready,
    input  inst_ready, out_valid, fn, src0_name, src0_index, src1_name, src1_index,
           dest_interim_wrt, dest_interim_index, dest_weight_wrt, dest_weight_index,
           dest_pu_neigh_wrt, dest_pe_neigh_wrt, dest_pe_bus_wrt, dest_pe_bus_index,
           dest_gb_bus_wrt, dest_gb_bus_index, repeat_left, issue_count
  );

  modport slave (
    input  inst_word, inst_valid, out_ready,
    output inst_ready, out_valid, fn, src0_name, src0_index, src1_name, src1_index,
           dest_interim_wrt, dest_interim_index, dest_weight_wrt, dest_weight_index,
           dest_pu_neigh_wrt, dest_pe_neigh_wrt, dest_pe_bus_wrt, dest_pe_bus_index,
           dest_gb_bus_wrt, dest_gb_bus_index, repeat_left, issue_count
  );
endinterface

// File: rtl/inst_decode_pipe.sv
// Registered valid/ready instruction decode stage for a PE, with a REPEAT prefix that
// re-issues the following instruction N extra times without refetch.
module inst_decode_pipe #(
  parameter int unsigned     FN_LEN           = 3,
  parameter int unsigned     NAME_LEN         = 3,
  parameter int unsigned     INDEX_LEN        = 8,
  parameter int unsigned     WEIGHT_ADDR_LEN  = 5,
  parameter int unsigned     INTERIM_ADDR_LEN = 2,
  parameter int unsigned     PE_BUS_INDEX_LEN = 4,
  parameter int unsigned     GB_BUS_INDEX_LEN = 4,
  parameter logic [FN_LEN-1:0] REPEAT_FN      = FN_LEN'(3'b111),
  parameter int unsigned     CNT_LEN          = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  inst_decode_pipe_if.slave  bus
);
  // Field offsets, counted from the LSB of the instruction word
  localparam int unsigned OFF_GB   = 0;
  localparam int unsigned OFF_PEB  = OFF_GB + GB_BUS_INDEX_LEN;
  localparam int unsigned OFF_PEN  = OFF_PEB + PE_BUS_INDEX_LEN;
  localparam int unsigned OFF_PUN  = OFF_PEN + 1;
  localparam int unsigned OFF_WI   = OFF_PUN + 1;
  localparam int unsigned OFF_WW   = OFF_WI + WEIGHT_ADDR_LEN;
  localparam int unsigned OFF_II   = OFF_WW + 1;
  localparam int unsigned OFF_IW   = OFF_II + INTERIM_ADDR_LEN;
  localparam int unsigned OFF_S1I  = OFF_IW + 1;
  localparam int unsigned OFF_S1N  = OFF_S1I + INDEX_LEN;
  localparam int unsigned OFF_S0I  = OFF_S1N + NAME_LEN;
  localparam int unsigned OFF_S0N  = OFF_S0I + INDEX_LEN;
  localparam int unsigned OFF_FN   = OFF_S0N + NAME_LEN;
  localparam int unsigned INST_LEN = OFF_FN + FN_LEN;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [INST_LEN-1:0]   data_q, data_d;
  logic [INDEX_LEN-1:0]  rep_left_q, rep_left_d;
  logic                  rep_pending_q, rep_pending_d;
  logic [INDEX_LEN-1:0]  rep_cnt_q, rep_cnt_d;
  logic [CNT_LEN-1:0]    issue_cnt_q, issue_cnt_d;

  logic out_valid;
  logic last_issue;
  logic handshake;
  logic slot_free;
  logic accept;
  logic is_repeat;

  assign out_valid  = (state_q == S_HOLD);
  assign last_issue = (rep_left_q == '0);
  assign handshake  = out_valid && bus.out_ready;
  assign slot_free  = !out_valid || handshake;
  assign accept     = bus.inst_valid && bus.inst_ready;
  assign is_repeat  = (bus.inst_word[OFF_FN +: FN_LEN] == REPEAT_FN);

  // Only take a new word once the held one has issued its final copy
  assign bus.inst_ready = !flush && (!out_valid || (bus.out_ready && last_issue));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_EMPTY;
      data_q        <= '0;
      rep_left_q    <= '0;
      rep_pending_q <= 1'b0;
      rep_cnt_q     <= '0;
      issue_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      rep_left_q    <= rep_left_d;
      rep_pending_q <= rep_pending_d;
      rep_cnt_q     <= rep_cnt_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  // Next state: flush clears everything but the issue counter; a freed slot either
  // loads a normal word or empties (and zeroes the fields so idle outputs read 0)
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    rep_left_d    = rep_left_q;
    rep_pending_d = rep_pending_q;
    rep_cnt_d     = rep_cnt_q;
    issue_cnt_d   = issue_cnt_q;

    if (flush) begin
      state_d       = S_EMPTY;
      data_d        = '0;
      rep_left_d    = '0;
      rep_pending_d = 1'b0;
    end else begin
      if (handshake) begin
        issue_cnt_d = issue_cnt_q + CNT_LEN'(1);
      end

      if (handshake && !last_issue) begin
        rep_left_d = rep_left_q - INDEX_LEN'(1);
      end else if (slot_free) begin
        if (accept && !is_repeat) begin
          state_d       = S_HOLD;
          data_d        = bus.inst_word;
          rep_left_d    = rep_pending_q ? rep_cnt_q : '0;
          rep_pending_d = 1'b0;
        end else begin
          state_d    = S_EMPTY;
          data_d     = '0;
          rep_left_d = '0;
        end
        if (accept && is_repeat) begin
          rep_pending_d = 1'b1;
          rep_cnt_d     = bus.inst_word[OFF_S0I +: INDEX_LEN];
        end
      end
    end
  end

  assign bus.out_valid          = out_valid;
  assign bus.fn                 = data_q[OFF_FN  +: FN_LEN];
  assign bus.src0_name          = data_q[OFF_S0N +: NAME_LEN];
  assign bus.src0_index         = data_q[OFF_S0I +: INDEX_LEN];
  assign bus.src1_name          = data_q[OFF_S1N +: NAME_LEN];
  assign bus.src1_index         = data_q[OFF_S1I +: INDEX_LEN];
  assign bus.dest_interim_wrt   = data_q[OFF_IW];
  assign bus.dest_interim_index = data_q[OFF_II  +: INTERIM_ADDR_LEN];
  assign bus.dest_weight_wrt    = data_q[OFF_WW];
  assign bus.dest_weight_index  = data_q[OFF_WI  +: WEIGHT_ADDR_LEN];
  assign bus.dest_pu_neigh_wrt  = data_q[OFF_PUN];
  assign bus.dest_pe_neigh_wrt  = data_q[OFF_PEN];
  assign bus.dest_pe_bus_wrt    = data_q[OFF_PEB + PE_BUS_INDEX_LEN - 1];
  assign bus.dest_pe_bus_index  = data_q[OFF_PEB +: PE_BUS_INDEX_LEN - 1];
  assign bus.dest_gb_bus_wrt    = data_q[OFF_GB + GB_BUS_INDEX_LEN - 1];
  assign bus.dest_gb_bus_index  = data_q[OFF_GB  +: GB_BUS_INDEX_LEN - 1];
  assign bus.repeat_left        = rep_left_q;
  assign bus.issue_count        = issue_cnt_q;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed bench for inst_decode_pipe: decode, flow control, REPEAT, flush, async reset,
// plus a narrow-counter instance for issue_count wrap.
module tb_inst_decode_pipe;
  typedef struct packed {
    logic [2:0] fn;
    logic [2:0] s0n;
    logic [7:0] s0i;
    logic [2:0] s1n;
    logic [7:0] s1i;
    logic       iw;
    logic [1:0] ii;
    logic       ww;
    logic [4:0] wi;
    logic       pun;
    logic       pen;
    logic       pbw;
    logic [2:0] pbi;
    logic       gbw;
    logic [2:0] gbi;
  } word_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  inst_decode_pipe_if bi ();
  inst_decode_pipe_if #(.CNT_LEN(4)) wi ();

  inst_decode_pipe u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bi.slave)
  );

  inst_decode_pipe #(.CNT_LEN(4)) u_wrap (
    .clk   (clk),
    .rstn  (rstn),
    .flush (1'b0),
    .bus   (wi.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t obs();
    return {bi.fn, bi.src0_name, bi.src0_index, bi.src1_name, bi.src1_index,
            bi.dest_interim_wrt, bi.dest_interim_index, bi.dest_weight_wrt, bi.dest_weight_index,
            bi.dest_pu_neigh_wrt, bi.dest_pe_neigh_wrt, bi.dest_pe_bus_wrt, bi.dest_pe_bus_index,
            bi.dest_gb_bus_wrt, bi.dest_gb_bus_index};
  endfunction

  task automatic chk_out(input string tag, input logic v, input word_t w, input int rl, input int ic);
    word_t exp_w;
    exp_w = v ? w : '0;
    check({tag, ".valid"}, 64'(bi.out_valid), 64'(v));
    check({tag, ".fields"}, 64'(obs()), 64'(exp_w));
    check({tag, ".rep_left"}, 64'(bi.repeat_left), 64'(rl));
    check({tag, ".issue"}, 64'(bi.issue_count), 64'(ic));
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    #1;
    check({tag, ".inst_ready"}, 64'(bi.inst_ready), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input word_t w, input logic v);
    bi.inst_word  = w;
    bi.inst_valid = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_t z, a, w, x, y, zz, w6, w7, w5;
    word_t r3, r2, r1, r255, r5;
    word_t b [4];
    word_t c [3];
    int n;

    z    = '0;
    a    = '{fn: 3'b010, s0i: 8'h5A, ww: 1'b1, wi: 5'h13, default: '0};
    w    = '{fn: 3'b001, s0n: 3'd5, s0i: 8'h11, s1n: 3'd2, s1i: 8'h22, iw: 1'b1, ii: 2'd3, pun: 1'b1, default: '0};
    x    = '{fn: 3'b100, s1i: 8'h99, pen: 1'b1, gbw: 1'b1, gbi: 3'd6, default: '0};
    y    = '{fn: 3'b011, s0i: 8'h77, default: '0};
    zz   = '{fn: 3'b110, s1n: 3'd7, ww: 1'b1, wi: 5'h1F, default: '0};
    w6   = '{fn: 3'b101, s0i: 8'hA5, pbw: 1'b1, pbi: 3'd5, default: '0};
    w7   = '{fn: 3'b010, s0n: 3'd1, ii: 2'd2, default: '0};
    w5   = '{fn: 3'b011, s1i: 8'hFE, gbi: 3'd7, default: '0};
    r3   = '{fn: 3'b111, s0i: 8'd3, s1i: 8'h44, default: '0};
    r2   = '{fn: 3'b111, s0i: 8'd2, default: '0};
    r1   = '{fn: 3'b111, s0i: 8'd1, default: '0};
    r255 = '{fn: 3'b111, s0i: 8'hFF, default: '0};
    r5   = '{fn: 3'b111, s0i: 8'd5, default: '0};
    b[0] = '{fn: 3'd0, s1n: 3'd1, s1i: 8'hC0, pbw: 1'b1, pbi: 3'd0, default: '0};
    b[1] = '{fn: 3'd1, s1n: 3'd2, s1i: 8'hC1, pbw: 1'b1, pbi: 3'd1, default: '0};
    b[2] = '{fn: 3'd2, s1n: 3'd3, s1i: 8'hC2, pbw: 1'b1, pbi: 3'd2, default: '0};
    b[3] = '{fn: 3'd3, s1n: 3'd4, s1i: 8'hC3, pbw: 1'b1, pbi: 3'd3, default: '0};
    c[0] = '{fn: 3'd4, s0i: 8'h01, iw: 1'b1, default: '0};
    c[1] = '{fn: 3'd5, s0i: 8'h02, gbw: 1'b1, default: '0};
    c[2] = '{fn: 3'd6, s0i: 8'h03, pun: 1'b1, default: '0};

    bi.inst_word = '0; bi.inst_valid = 1'b0; bi.out_ready = 1'b0;
    wi.inst_word = '0; wi.inst_valid = 1'b0; wi.out_ready = 1'b0;

    // Reset state
    #12;
    chk_out("rst", 1'b0, z, 0, 0);
    chk_rdy("rst", 1'b1);
    rstn = 1'b1;

    // Single word, latency 1
    bi.out_ready = 1'b1;
    drive(a, 1'b1);
    chk_rdy("t1", 1'b1);
    tick(); chk_out("t1.a", 1'b1, a, 0, 0);
    drive(z, 1'b0);
    tick(); chk_out("t1.b", 1'b0, z, 0, 1);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(b[i], 1'b1);
      chk_rdy("t2", 1'b1);
      tick(); chk_out("t2", 1'b1, b[i], 0, 1 + i);
    end
    drive(z, 1'b0);
    tick(); chk_out("t2.end", 1'b0, z, 0, 5);

    // Stall pattern 1,0,0,1
    drive(c[0], 1'b1);
    tick(); chk_out("t3.0", 1'b1, c[0], 0, 5);
    drive(c[1], 1'b1);
    chk_rdy("t3.r1", 1'b1);
    tick(); chk_out("t3.1", 1'b1, c[1], 0, 6);
    bi.out_ready = 1'b0; drive(c[2], 1'b1);
    chk_rdy("t3.s1", 1'b0);
    tick(); chk_out("t3.s1", 1'b1, c[1], 0, 6);
    chk_rdy("t3.s2", 1'b0);
    tick(); chk_out("t3.s2", 1'b1, c[1], 0, 6);
    bi.out_ready = 1'b1;
    chk_rdy("t3.r2", 1'b1);
    tick(); chk_out("t3.2", 1'b1, c[2], 0, 7);
    drive(z, 1'b0);
    tick(); chk_out("t3.end", 1'b0, z, 0, 8);

    // REPEAT 3 then W: four issues, then X once
    drive(r3, 1'b1);
    chk_rdy("t4.rep", 1'b1);
    tick(); chk_out("t4.rep", 1'b0, z, 0, 8);
    drive(w, 1'b1);
    tick(); chk_out("t4.w3", 1'b1, w, 3, 8);
    drive(x, 1'b1);
    chk_rdy("t4.b3", 1'b0);
    tick(); chk_out("t4.w2", 1'b1, w, 2, 9);
    chk_rdy("t4.b2", 1'b0);
    tick(); chk_out("t4.w1", 1'b1, w, 1, 10);
    chk_rdy("t4.b1", 1'b0);
    tick(); chk_out("t4.w0", 1'b1, w, 0, 11);
    chk_rdy("t4.b0", 1'b1);
    tick(); chk_out("t4.x", 1'b1, x, 0, 12);
    drive(z, 1'b0);
    tick(); chk_out("t4.end", 1'b0, z, 0, 13);

    // Second REPEAT overwrites count; stall holds repeat_left
    drive(r2, 1'b1);
    tick(); chk_out("t6.r2", 1'b0, z, 0, 13);
    drive(r1, 1'b1);
    tick();
    drive(w6, 1'b1);
    tick(); chk_out("t6.w1", 1'b1, w6, 1, 13);
    drive(z, 1'b0); bi.out_ready = 1'b0;
    tick(); chk_out("t6.stall", 1'b1, w6, 1, 13);
    bi.out_ready = 1'b1;
    tick(); chk_out("t6.w0", 1'b1, w6, 0, 14);
    tick(); chk_out("t6.end", 1'b0, z, 0, 15);

    // Maximum repeat count: 256 issues
    drive(r255, 1'b1);
    tick();
    drive(w7, 1'b1);
    tick(); chk_out("t7.start", 1'b1, w7, 255, 15);
    drive(z, 1'b0);
    n = 0;
    while (bi.out_valid && n < 400) begin
      tick();
      n++;
    end
    check("t7.issues", 64'(n), 64'(256));
    chk_out("t7.end", 1'b0, z, 0, 271);

    // Flush mid-repeat with a word offered
    drive(r5, 1'b1);
    tick();
    drive(w5, 1'b1);
    tick(); chk_out("t5.w5", 1'b1, w5, 5, 271);
    drive(z, 1'b0);
    tick(); tick();
    tick(); chk_out("t5.w2", 1'b1, w5, 2, 274);
    flush = 1'b1; drive(y, 1'b1);
    chk_rdy("t5.flush", 1'b0);
    tick(); chk_out("t5.flush", 1'b0, z, 0, 274);
    flush = 1'b0; drive(z, 1'b0);
    tick(); chk_out("t5.after", 1'b0, z, 0, 274);
    // Flush also drops a pending REPEAT
    drive(r2, 1'b1);
    tick();
    flush = 1'b1; drive(z, 1'b0);
    tick();
    flush = 1'b0; drive(zz, 1'b1);
    tick(); chk_out("t5.pend", 1'b1, zz, 0, 274);
    drive(z, 1'b0);
    tick(); chk_out("t5.end", 1'b0, z, 0, 275);

    // Async reset mid-repeat
    drive(r5, 1'b1);
    tick();
    drive(w, 1'b1); bi.out_ready = 1'b0;
    tick(); chk_out("t8.held", 1'b1, w, 5, 275);
    drive(z, 1'b0);
    #2 rstn = 1'b0;
    #1 chk_out("t8.rst", 1'b0, z, 0, 0);
    #6 rstn = 1'b1;
    bi.out_ready = 1'b1; drive(w, 1'b1);
    tick(); chk_out("t8.post", 1'b1, w, 0, 0);
    drive(z, 1'b0);
    tick(); chk_out("t8.end", 1'b0, z, 0, 1);

    // Narrow counter wraps all-ones -> 0
    wi.out_ready = 1'b1;
    wi.inst_word = 44'(w);
    wi.inst_valid = 1'b1;
    repeat (16) tick();
    check("wrap.ones", 64'(wi.issue_count), 64'(15));
    tick();
    check("wrap.zero", 64'(wi.issue_count), 64'(0));
    wi.inst_valid = 1'b0;
    tick();
    check("wrap.one", 64'(wi.issue_count), 64'(1));
    check("wrap.valid", 64'(wi.out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_decode_pipe.md
Name: inst_decode_pipe

Overview:
- Registered, handshaked instruction decode stage for a PE. Sits between the PE instruction memory and the PE datapath control.
- Splits a parametrised instruction word into function, source and destination fields.
- Holds each decoded instruction in an output register under valid/ready flow control.
- Supports a REPEAT prefix instruction that re-issues the following instruction N extra times without refetch.

Parameters:
FN_LEN, 3, function field width
NAME_LEN, 3, source namespace field width
INDEX_LEN, 8, source index field width
WEIGHT_ADDR_LEN, 5, weight-buffer destination address width
INTERIM_ADDR_LEN, 2, interim-buffer destination address width
PE_BUS_INDEX_LEN, 4, PE-bus field width (1 write bit + PE_BUS_INDEX_LEN-1 index bits)
GB_BUS_INDEX_LEN, 4, global-bus field width (1 write bit + GB_BUS_INDEX_LEN-1 index bits)
REPEAT_FN, 3'b111 (FN_LEN wide), fn code marking a REPEAT prefix
CNT_LEN, 16, issue counter width
INST_LEN, FN_LEN+2*(NAME_LEN+INDEX_LEN)+1+INTERIM_ADDR_LEN+1+WEIGHT_ADDR_LEN+2+PE_BUS_INDEX_LEN+GB_BUS_INDEX_LEN (44 at defaults), derived

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of held instruction and pending repeat
inst_word  in  INST_LEN  instruction word
inst_valid  in  1  inst_word valid
inst_ready  out  1  stage accepts inst_word this cycle
out_valid  out  1  decoded outputs valid
out_ready  in  1  datapath consumes outputs this cycle
fn  out  FN_LEN  function
src0_name / src1_name  out  NAME_LEN each  source namespaces
src0_index / src1_index  out  INDEX_LEN each  source indices
dest_interim_wrt  out  1 ; dest_interim_index  out  INTERIM_ADDR_LEN
dest_weight_wrt  out  1 ; dest_weight_index  out  WEIGHT_ADDR_LEN
dest_pu_neigh_wrt, dest_pe_neigh_wrt  out  1 each
dest_pe_bus_wrt  out  1 ; dest_pe_bus_index  out  PE_BUS_INDEX_LEN-1
dest_gb_bus_wrt  out  1 ; dest_gb_bus_index  out  GB_BUS_INDEX_LEN-1
repeat_left  out  INDEX_LEN  remaining extra issues of held instruction
issue_count  out  CNT_LEN  completed output handshakes, wraps modulo 2^CNT_LEN

Behaviour:
- Field order in inst_word, MSB to LSB: fn, src0_name, src0_index, src1_name, src1_index, interim_wrt, interim_index, weight_wrt, weight_index, pu_neigh_wrt, pe_neigh_wrt, pe_bus_wrt, pe_bus_index, gb_bus_wrt, gb_bus_index.
- Reset (rstn low, async): out_valid=0, all decoded outputs 0, repeat_left=0, issue_count=0, rep_pending=0, rep_cnt=0. Reset mid-repeat discards the held instruction and the remaining count.
- Accept = inst_valid & inst_ready.
- inst_ready = !flush & (!out_valid | (out_ready & repeat_left==0)).
- Normal accept (fn != REPEAT_FN), cycle t:
  - Fields registered; out_valid=1 from t+1. Latency 1 cycle.
  - repeat_left <= rep_cnt if rep_pending, else 0; rep_pending cleared.
- REPEAT accept: not emitted. rep_pending<=1, rep_cnt<=src0_index. out_valid drops if the held instruction completes that cycle. A second REPEAT before a normal instruction overwrites rep_cnt.
- Output handshake (out_valid & out_ready):
  - issue_count increments.
  - If repeat_left>0: repeat_left decrements and out_valid stays 1 with identical fields.
  - Else out_valid<=1 and fields load if a normal accept occurs the same cycle; otherwise out_valid<=0.
- While out_valid=1 and out_ready=0: all outputs held stable; repeat_left does not change.
- Repeat count 0 behaves as a plain instruction. Maximum count 2^INDEX_LEN-1 gives 2^INDEX_LEN issues.
- out_valid=0: all decoded field outputs driven 0.
- flush=1: next cycle out_valid=0, repeat_left=0, rep_pending=0. issue_count unchanged. Flush wins over a simultaneous inst_valid (inst_ready is 0).
- issue_count wraps from all-ones to 0.

Test Plan:
- Reset then single word fn=3'b010, src0_index=8'h5A, weight_wrt=1, weight_index=5'h13, out_ready=1 -> out_valid at t+1 for one cycle with matching fields; issue_count=1; all fields 0 afterwards.
- Back-to-back 4 words, out_ready=1 -> one output per cycle, inst_ready constantly 1, issue_count=4.
- out_ready toggled 1,0,0,1 with streaming input -> no drop or duplicate; fields stable while stalled; inst_ready low during stall.
- REPEAT with src0_index=3, then word W -> W presented for 4 handshakes with repeat_left 3,2,1,0; inst_ready low until last; next word issued once.
- Assert flush while repeat_left=2 and inst_valid=1 -> out_valid=0 next cycle, word not accepted, issue_count unchanged. Then async rstn low mid-stream -> all outputs 0 immediately.
- CNT_LEN=4: 17 handshakes -> issue_count reads 1.
